// File: rtl/sound_pcm_converter.sv
// rtl/sound_pcm_converter.sv - SM510 speaker bit to 16-bit PCM; optional SOUND_DC_BLOCK_EN high-pass stage
module sound_pcm_converter #(
  parameter int PHASE_INC    = 48000,
  parameter int PHASE_MOD    = 131072000,
  parameter int FILTER_DIV   = 64,
  parameter int FILTER_SHIFT = 6,
  parameter int AMPLITUDE    = 16383
) (
  input  logic               clk_sys_131_072,
  input  logic               reset,
  input  logic               sound,
  input  logic [1:0]         volume,
  output logic signed [15:0] sample,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun
);

  localparam int PW = $clog2(PHASE_MOD) + 1;
  localparam int DW = (FILTER_DIV > 1) ? $clog2(FILTER_DIV) : 1;
  localparam logic [15:0] AMP = 16'(AMPLITUDE);

  logic               sound_r;
  logic [PW-1:0]      phase;
  logic [PW-1:0]      phase_sum;
  logic               tick;
  logic [DW-1:0]      div_cnt;
  logic               iir_update;
  logic [15:0]        mag;
  logic signed [23:0] tgt_mag;
  logic signed [23:0] target;
  logic signed [23:0] acc;
  logic signed [24:0] diff;
  logic signed [23:0] step;
  logic signed [15:0] out_val;

  // Fractional sample-rate generator: tick whenever the accumulator wraps.
  assign phase_sum  = phase + PW'(PHASE_INC);
  assign tick       = (phase_sum >= PW'(PHASE_MOD));
  assign iir_update = (div_cnt == DW'(FILTER_DIV - 1));

  // Volume selects the target magnitude; mute drives the filter toward zero.
  always_comb begin
    mag = 16'd0;
    case (volume)
      2'd1:    mag = AMP >> 2;
      2'd2:    mag = AMP >> 1;
      2'd3:    mag = AMP;
      default: mag = 16'd0;
    endcase
  end

  assign tgt_mag = {mag, 8'h00};
  assign target  = sound_r ? tgt_mag : -tgt_mag;
  // 25-bit difference keeps full range; shifted step always fits back in 24 bits.
  assign diff    = {target[23], target} - {acc[23], acc};
  assign step    = 24'(diff >>> FILTER_SHIFT);

  // Input register, phase accumulator, decimation divider and IIR state.
  always_ff @(posedge clk_sys_131_072) begin
    if (reset) begin
      sound_r <= 1'b0;
      phase   <= '0;
      div_cnt <= '0;
      acc     <= '0;
    end else begin
      sound_r <= sound;
      phase   <= tick ? (phase_sum - PW'(PHASE_MOD)) : phase_sum;
      div_cnt <= iir_update ? '0 : (div_cnt + 1'b1);
      if (iir_update) begin
        acc <= acc + step;
      end
    end
  end

`ifdef SOUND_DC_BLOCK_EN
  logic signed [23:0] dc_x;
  logic signed [23:0] dc_x_prev;
  logic signed [23:0] dc_y;
  logic signed [23:0] dc_y_next;

  assign dc_x      = {{8{acc[23]}}, acc[23:8]};
  assign dc_y_next = dc_x - dc_x_prev + dc_y - (dc_y >>> 10);

  // High-pass state advances once per output sample.
  always_ff @(posedge clk_sys_131_072) begin
    if (reset) begin
      dc_x_prev <= '0;
      dc_y      <= '0;
    end else if (tick) begin
      dc_x_prev <= dc_x;
      dc_y      <= dc_y_next;
    end
  end

  // Clamp the high-pass result into the 16-bit sample range.
  always_comb begin
    out_val = dc_y[15:0];
    if (dc_y > 24'sd32767) begin
      out_val = 16'sd32767;
    end else if (dc_y < -24'sd32768) begin
      out_val = -16'sd32768;
    end
  end
`else
  assign out_val = acc[23:8];
`endif

  // Single-entry output register with sticky overrun on overwrite of an unread sample.
  always_ff @(posedge clk_sys_131_072) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (tick) begin
      sample       <= out_val;
      sample_valid <= 1'b1;
      if (sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sound_pcm_converter.sv
// tb/tb_sound_pcm_converter.sv - self-checking bench for sound_pcm_converter
module tb_sound_pcm_converter;

  // Faster sample clock and filter update keep the run short.
  localparam int PHASE_INC    = 48000;
  localparam int PHASE_MOD    = 1024000;
  localparam int FILTER_DIV   = 4;
  localparam int FILTER_SHIFT = 6;
  localparam int AMPLITUDE    = 16383;

  logic               clk_sys_131_072 = 1'b0;
  logic               reset = 1'b1;
  logic               sound = 1'b0;
  logic [1:0]         volume = 2'd3;
  logic               sample_ready = 1'b1;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               overrun;

  int checks = 0;
  int errors = 0;

  bit model_on = 1'b0;
  int m_cyc = 0;
  bit m_sound_r, m_valid, m_over;
  int m_acc, m_sample, m_xp, m_y;
  int m_v, m_mag, m_tgt, m_x, m_out, m_ynew;

  sound_pcm_converter #(
    .PHASE_INC(PHASE_INC), .PHASE_MOD(PHASE_MOD), .FILTER_DIV(FILTER_DIV),
    .FILTER_SHIFT(FILTER_SHIFT), .AMPLITUDE(AMPLITUDE)
  ) dut (
    .clk_sys_131_072(clk_sys_131_072),
    .reset(reset),
    .sound(sound),
    .volume(volume),
    .sample(sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun(overrun)
  );

  always #5 clk_sys_131_072 = ~clk_sys_131_072;

  function automatic int floordiv(int a, int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // A sample is due on cycle k when the count of whole samples elapsed steps up.
  function automatic bit tick_at(int k);
    longint a, b;
    a = (longint'(k) * PHASE_INC) / PHASE_MOD;
    b = (longint'(k - 1) * PHASE_INC) / PHASE_MOD;
    return a != b;
  endfunction

  // Reference model: arithmetic form of the converter, one step per clock.
  initial forever begin
    @(posedge clk_sys_131_072);
    if (reset) begin
      m_cyc = 0; m_sound_r = 0; m_acc = 0; m_sample = 0;
      m_valid = 0; m_over = 0; m_xp = 0; m_y = 0;
    end else begin
      m_cyc++;
      m_x = floordiv(m_acc, 256);
`ifdef SOUND_DC_BLOCK_EN
      m_out = (m_y > 32767) ? 32767 : ((m_y < -32768) ? -32768 : m_y);
`else
      m_out = m_x;
`endif
      if (tick_at(m_cyc)) begin
        if (m_valid && !sample_ready) m_over = 1;
        m_sample = m_out;
        m_valid  = 1;
        m_ynew   = m_x - m_xp + m_y - floordiv(m_y, 1024);
        m_xp     = m_x;
        m_y      = m_ynew;
      end else if (m_valid && sample_ready) begin
        m_valid = 0;
      end
      if (m_cyc % FILTER_DIV == 0) begin
        m_v   = int'(volume);
        m_mag = (m_v == 0) ? 0 : AMPLITUDE / (1 << (3 - m_v));
        m_tgt = (m_sound_r ? m_mag : -m_mag) * 256;
        m_acc = m_acc + floordiv(m_tgt - m_acc, 1 << FILTER_SHIFT);
      end
      m_sound_r = sound;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  initial forever begin
    @(negedge clk_sys_131_072);
    if (model_on) begin
      checks++;
      if (sample !== m_sample[15:0] || sample_valid !== m_valid || overrun !== m_over) begin
        errors++;
        $display("FAIL model_compare cyc=%0d sample=%0d exp=%0d valid=%b exp=%b overrun=%b exp=%b",
                 m_cyc, sample, m_sample, sample_valid, m_valid, overrun, m_over);
      end
    end
  end

  task automatic check(string name, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clk_sys_131_072);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic wait_valid(string name);
    int n;
    n = 0;
    while (!sample_valid && n < 200) begin
      cycles(1);
      n++;
    end
    check(name, int'(sample_valid), 1, 1);
  endtask

  task automatic wait_next_tick();
    int n;
    n = 0;
    do begin
      cycles(1);
      n++;
    end while (!tick_at(m_cyc) && n < 200);
    check("tick_wait", n, 1, 199);
  endtask

  initial begin
    int cnt;
    int s1;
    cycles(2);
    model_on = 1'b1;
    check("reset_sample", int'(sample), 0, 0);
    check("reset_valid", int'(sample_valid), 0, 0);
    check("reset_overrun", int'(overrun), 0, 0);

    // Tick count over a whole number of phase periods.
    sound = 1'b0; volume = 2'd3; sample_ready = 1'b1;
    reset = 1'b0;
    cnt = 0;
    while (m_cyc < 10240) begin
      cycles(1);
      if (sample_valid) cnt++;
    end
    check("tick_count", cnt, 480, 480);
    check("last_tick_valid", int'(sample_valid), 1, 1);
    check("no_overrun", int'(overrun), 0, 0);

`ifndef SOUND_DC_BLOCK_EN
    // Steady-state levels.
    sound = 1'b1; cycles(5000);
    check("full_pos", int'(sample), 16382, 16383);
    sound = 1'b0; cycles(5000);
    check("full_neg", int'(sample), -16383, -16383);
    volume = 2'd2; sound = 1'b1; cycles(5000);
    check("half_pos", int'(sample), 8190, 8191);
    volume = 2'd0; cycles(5000);
    check("mute", int'(sample), -1, 0);
`endif

    // Overwrite of an unread sample.
    volume = 2'd3; sound = 1'b1; sample_ready = 1'b0;
    do_reset();
    wait_valid("ovr_first_valid");
    s1 = int'(sample);
    wait_next_tick();
    check("ovr_valid", int'(sample_valid), 1, 1);
    check("ovr_flag", int'(overrun), 1, 1);
    check("ovr_replace", int'(sample), s1 + 1, 32767);
    sample_ready = 1'b1;
    cycles(1);
    check("ovr_drain", int'(sample_valid), 0, 0);
    check("ovr_sticky", int'(overrun), 1, 1);

    // Transfer and new sample on the same edge.
    sample_ready = 1'b0;
    do_reset();
    wait_valid("tt_first_valid");
    s1 = int'(sample);
    while (!tick_at(m_cyc + 1)) cycles(1);
    sample_ready = 1'b1;
    cycles(1);
    check("tt_valid", int'(sample_valid), 1, 1);
    check("tt_overrun", int'(overrun), 0, 0);
    check("tt_new_data", int'(sample), s1 + 1, 32767);
    sample_ready = 1'b0;
    cycles(3);

    // Reset while a sample is pending.
    reset = 1'b1;
    cycles(1);
    check("rst_valid", int'(sample_valid), 0, 0);
    check("rst_sample", int'(sample), 0, 0);
    check("rst_overrun", int'(overrun), 0, 0);
    reset = 1'b0;
    sample_ready = 1'b1;
    cycles(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached time=%0t limit=2000000", $time);
    $fatal(1);
  end

endmodule
